// File: rtl/add_serial_n.sv
// -----------------------------------------------------------------------------
// add_serial_n
// Multi-cycle adder/subtractor. A WIDTH-bit operation is carried out DIGIT bits
// per clock through a single DIGIT-bit ripple stage, with a start/ready/done
// handshake. Results are registered and held until the next completion.
//
// Parameters
//   WIDTH  operand/result width; must be a multiple of DIGIT
//   DIGIT  bits processed per clock, 1..WIDTH
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request an operation; taken only when ready=1
//   Sub    0: S = A + B + Cin, 1: S = A - B (sampled with start)
//   A, B   operands, sampled on the accepting edge
//   Cin    carry-in for add mode, sampled on the accepting edge
//   ready  start will be accepted (IDLE or DONE)
//   busy   operation in progress (RUN)
//   done   one-cycle pulse: S/Cout/V are new
//   S      registered result
//   Cout   carry out of the MSB (in Sub mode 1 = no borrow)
//   V      signed overflow
// -----------------------------------------------------------------------------
module add_serial_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  // Low for the first edge after reset release so a start presented on that
  // edge is ignored.
  logic             armed;

  // One DIGIT-bit ripple stage.
  logic [DIGIT-1:0]       a_dig;
  logic [DIGIT-1:0]       b_dig;
  logic [DIGIT-1:0]       sum_dig;
  logic                   carry_out;
  logic                   carry_msb;
  logic [WIDTH+DIGIT-1:0] res_cat;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally) so no latch can be inferred.
  always_comb begin
    a_dig                = a_sh[DIGIT-1:0];
    b_dig                = b_sh[DIGIT-1:0];
    {carry_out, sum_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    // Carry into the top bit of this digit, recovered from its sum bit. On the
    // last digit that is the carry into bit WIDTH-1.
    carry_msb            = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum_dig[DIGIT-1];
    // New digit enters the result shifter from the top; the concatenation keeps
    // the slice legal even when DIGIT == WIDTH.
    res_cat              = {sum_dig, res_sh};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      armed  <= 1'b0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      S      <= '0;
      Cout   <= 1'b0;
      V      <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start && armed) begin
            a_sh  <= A;
            b_sh  <= Sub ? ~B : B;
            carry <= Sub ? 1'b1 : Cin;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            ready <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_cat[WIDTH+DIGIT-1:DIGIT];
          carry  <= carry_out;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            S     <= res_cat[WIDTH+DIGIT-1:DIGIT];
            Cout  <= carry_out;
            V     <= carry_msb ^ carry_out;
            done  <= 1'b1;
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial_n.sv
// -----------------------------------------------------------------------------
// tb_add_serial_n
// Bench for add_serial_n with two instances: DIGIT=1 (8 cycles/op) and DIGIT=4
// (2 cycles/op), both WIDTH=8. Stimulus pushes expected results (value plus
// the cycle done must appear in) into per-instance queues; monitors pop and
// compare whenever done is seen.
// -----------------------------------------------------------------------------
module tb_add_serial_n;

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       v;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, sub1, cin1, start4, sub4, cin4;
  logic [7:0] a1, b1, a4, b4;
  logic       ready1, busy1, done1, cout1, v1;
  logic       ready4, busy4, done4, cout4, v4;
  logic [7:0] s1, s4;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_serial_n #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .Sub(sub1), .A(a1), .B(b1), .Cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .V(v1)
  );

  add_serial_n #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .Sub(sub4), .A(a4), .B(b4), .Cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .S(s4), .Cout(cout4), .V(v4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic and sign rules.
  function automatic exp_t model(input bit sub, input logic [7:0] a, input logic [7:0] b,
                                 input bit cin);
    exp_t       e;
    logic [8:0] full;
    if (sub) begin
      e.s    = a - b;
      e.cout = (a >= b);
      e.v    = (a[7] != b[7]) && (e.s[7] != a[7]);
    end else begin
      full   = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      e.s    = full[7:0];
      e.cout = full[8];
      e.v    = (a[7] == b[7]) && (e.s[7] != a[7]);
    end
    e.cyc = 0;
    return e;
  endfunction

  // Called at a falling edge; the next rising edge is the accepting edge.
  task automatic issue(input int inst, input bit sub, input logic [7:0] a, input logic [7:0] b,
                       input bit cin, input bit hold);
    exp_t e;
    e = model(sub, a, b, cin);
    if (inst == 1) begin
      e.cyc = cyc + 1 + 8;
      q1.push_back(e);
      start1 = 1'b1; sub1 = sub; a1 = a; b1 = b; cin1 = cin;
    end else begin
      e.cyc = cyc + 1 + 2;
      q4.push_back(e);
      start4 = 1'b1; sub4 = sub; a4 = a; b4 = b; cin4 = cin;
    end
    @(negedge clk);
    if (!hold) begin
      if (inst == 1) start1 = 1'b0;
      else           start4 = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q1.size() + q4.size(), 0);
    q1.delete();
    q4.delete();
    @(negedge clk);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d1_unexpected_done: got done=1 expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("d1_S", s1, e.s);
        check("d1_Cout", cout1, e.cout);
        check("d1_V", v1, e.v);
        check("d1_done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL d4_unexpected_done: got done=1 expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("d4_S", s4, e.s);
        check("d4_Cout", cout4, e.cout);
        check("d4_V", v4, e.v);
        check("d4_done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    check("rst_ready1", ready1, 1);
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    check("rst_S1", s1, 0);
    check("rst_CoutV1", {cout1, v1}, 0);
    check("rst_ready4_busy4", {ready4, busy4, done4}, 3'b100);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // FF + 01: wraps to 00 with carry; busy for exactly 8 cycles.
    issue(1, 0, 8'hFF, 8'h01, 0, 0);
    for (int i = 0; i < 8; i++) begin
      check("busy_during_run", busy1, 1);
      check("ready_during_run", ready1, 0);
      @(negedge clk);
    end
    check("busy_after_done", busy1, 0);
    wait_drain();

    issue(1, 0, 8'h7F, 8'h01, 0, 0); wait_drain();
    issue(1, 0, 8'h10, 8'h20, 1, 0); wait_drain();
    issue(1, 1, 8'h05, 8'h07, 0, 0); wait_drain();
    issue(1, 1, 8'h80, 8'h01, 1, 0); wait_drain();

    // Start during RUN is ignored; operand changes during RUN have no effect.
    issue(1, 0, 8'h33, 8'h44, 0, 0);
    @(negedge clk);
    start1 = 1'b1; a1 = 8'hC3; b1 = 8'h77; sub1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
      @(negedge clk);
    end
    wait_drain();
    repeat (12) @(negedge clk);

    // Asynchronous reset in cycle 4 of RUN aborts the operation.
    issue(1, 0, 8'h9C, 8'h4D, 1, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_S", s1, 0);
    check("abort_CoutV", {cout1, v1}, 0);
    check("abort_busy_ready", {busy1, ready1}, 2'b01);
    check("abort_done", done1, 0);
    q1.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    repeat (10) @(negedge clk);
    issue(1, 0, 8'h12, 8'h34, 0, 0); wait_drain();

    // DIGIT=4, start held: A5+5B then 01+01 accepted on the DONE edge.
    issue(4, 0, 8'hA5, 8'h5B, 0, 1);
    begin
      exp_t e;
      e = model(0, 8'h01, 8'h01, 0);
      e.cyc = cyc + 5;
      q4.push_back(e);
    end
    a4 = 8'h01; b4 = 8'h01;
    repeat (3) @(negedge clk);
    start4 = 1'b0;
    wait_drain();

    // Randomised operations on both instances.
    for (int k = 0; k < 40; k++) begin
      issue((k % 2 == 0) ? 1 : 4, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0);
      wait_drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_serial_n.md
# add_serial_n

Parametrised multi-cycle adder/subtractor for the adder family. It generalises the single-bit full-adder cell to WIDTH-bit operands, processed DIGIT bits per clock through one internal DIGIT-bit ripple stage. It uses a start/ready/done handshake and adds subtract mode, signed overflow and held registered results. It sits between operand registers and any consumer that trades latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits added per clock cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; accepted only when ready=1.
- Sub  input  1  0: S = A + B + Cin. 1: S = A − B (Cin ignored). Sampled with start.
- A  input  WIDTH  operand A, sampled on the accepting edge.
- B  input  WIDTH  operand B, sampled on the accepting edge.
- Cin  input  1  carry-in for add mode, sampled on the accepting edge.
- ready  output  1  high when start will be accepted (state IDLE or DONE).
- busy  output  1  high in state RUN.
- done  output  1  one-cycle pulse; S, Cout and V are valid and new.
- S  output  WIDTH  result, registered and held until the next completion.
- Cout  output  1  carry out of the MSB. In Sub mode, 1 means no borrow.
- V  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Reset (asynchronous, any state): state=IDLE, S=0, Cout=0, V=0, done=0, busy=0, ready=1. Internal operand shifters, digit counter and carry are cleared.
- States:
  - IDLE → RUN on start.
  - RUN → DONE after the last digit.
  - DONE → RUN on start, else → IDLE.
- Accepting edge (start=1 and ready=1):
  - latch A, and B (or ~B if Sub=1);
  - load the internal carry with Cin (or 1 if Sub=1);
  - set digit counter to 0.
- RUN, each edge:
  - add the low DIGIT bits of the A and B shifters plus the carry;
  - shift the sum digit into the result shifter from the top;
  - shift both operand shifters right by DIGIT;
  - store the new carry and increment the counter.
- On the last digit (counter = WIDTH/DIGIT − 1):
  - load S from the completed result shifter;
  - Cout = final carry;
  - V = carry into bit WIDTH−1 XOR final carry (take the carry into the MSB from inside the last digit);
  - go to DONE.
- start while busy=1 is ignored and not queued. Changes on A, B, Cin or Sub during RUN have no effect.
- Arithmetic is modulo 2^WIDTH. No operand or result sign-extension.
- S, Cout and V change only at completion or reset. Earlier values hold through IDLE and RUN.

## Timing
- Let N = WIDTH/DIGIT and let the accepting edge be edge 0.
- Digits are processed on edges 1..N. S, Cout, V and done=1 appear after edge N.
- done is high for exactly one cycle (the DONE state). Latency from accepting edge to done = N cycles.
- busy is high from after edge 0 through edge N−1; ready is low over the same span.
- Back-to-back: start held high in DONE is accepted on edge N+1. Throughput is one result per N+1 cycles.
- Reset mid-RUN aborts the operation: no done pulse, and S/Cout/V read 0.
- start on the same edge as a reset release is ignored; the first accept is possible on the following edge.

## Test plan
- WIDTH=8, DIGIT=1: A=8'hFF, B=8'h01, Cin=0, Sub=0.
  -> done exactly 8 cycles after accept; S=8'h00, Cout=1, V=0; busy high for 8 cycles.
- WIDTH=8, DIGIT=1: A=8'h7F, B=8'h01 -> S=8'h80, Cout=0, V=1.
  - Then A=8'h10, B=8'h20, Cin=1 -> S=8'h31, Cout=0, V=0.
- Sub mode:
  - A=8'h05, B=8'h07 -> S=8'hFE, Cout=0, V=0.
  - A=8'h80, B=8'h01 -> S=8'h7F, Cout=1, V=1.
- Start while busy: pulse start with new operands at cycle 3 of RUN, and change A/B during RUN.
  -> the first result is unaffected; exactly one done pulse; the second start is not queued.
- Reset mid-operation: assert rst asynchronously during cycle 4 of RUN.
  -> immediately S=0, Cout=0, V=0, busy=0, ready=1; no done pulse. A fresh start afterwards completes normally.
- WIDTH=8, DIGIT=4, start held high continuously: 8'hA5 + 8'h5B, then 8'h01 + 8'h01.
  -> the first done comes 2 cycles after accept with S=8'h00, Cout=1, V=0.
  -> the second is accepted on the DONE edge, with done 3 cycles after the first and S=8'h02.
